// File: rtl/sm_multi_if.sv
// Command and status bundle for the sm_multi set/reset flag bank.
interface sm_multi_if #(
    parameter int unsigned CH    = 4,
    parameter int unsigned CNT_W = 8
);
    logic [CH-1:0]    a;
    logic [CH-1:0]    b;
    logic             tcnt_clr;
    logic [CH-1:0]    Q;
    logic [CH-1:0]    chg;
    logic [CH-1:0]    busy;
    logic [CNT_W-1:0] tcnt;

    modport master (output a, b, tcnt_clr, input Q, chg, busy, tcnt);
    modport slave  (input a, b, tcnt_clr, output Q, chg, busy, tcnt);
endinterface

// File: rtl/sm_multi.sv
// Bank of CH independent set/reset flags with selectable a=b=1 response,
// optional post-change lockout, change pulses and a saturating transition count.
module sm_multi #(
    parameter int unsigned CH       = 4,
    parameter int unsigned MODE     = 0,
    parameter int unsigned HOLD_CYC = 0,
    parameter int unsigned CNT_W    = 8
) (
    input logic       En,
    input logic       rst,
    sm_multi_if.slave bus
);
    localparam int unsigned PW    = $clog2(CH + 1);
    localparam int unsigned SUM_W = CNT_W + PW + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});
    localparam logic [7:0]       HOLD_LD = 8'(HOLD_CYC);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        LK = 2'd2
    } state_t;

    state_t     st [CH];
    logic [7:0] hc [CH];

    logic [CH-1:0]    nxt_c;
    logic [CH-1:0]    chg_c;
    logic [PW-1:0]    pop_c;
    logic [SUM_W-1:0] sum_c;

    // Per-channel command decode; a busy channel keeps its current value.
    always_comb begin
        nxt_c = bus.Q;
        chg_c = '0;
        for (int i = 0; i < CH; i++) begin
            if (!bus.busy[i]) begin
                case ({bus.a[i], bus.b[i]})
                    2'b10:   nxt_c[i] = 1'b1;
                    2'b01:   nxt_c[i] = 1'b0;
                    2'b11: begin
                        case (MODE)
                            0:       nxt_c[i] = 1'b1;
                            1:       nxt_c[i] = 1'b0;
                            2:       nxt_c[i] = ~bus.Q[i];
                            default: nxt_c[i] = bus.Q[i];
                        endcase
                    end
                    default: nxt_c[i] = bus.Q[i];
                endcase
            end
            chg_c[i] = nxt_c[i] ^ bus.Q[i];
        end
    end

    // Transition count for this edge, summed wide enough that it cannot wrap.
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < CH; i++) begin
            pop_c = pop_c + PW'(chg_c[i]);
        end
        sum_c = SUM_W'(bus.tcnt) + SUM_W'(pop_c);
    end

    // Per-channel S0/S1/LK state machine, lockout counters and registered outputs.
    always_ff @(posedge En or posedge rst) begin
        if (rst) begin
            bus.Q    <= '0;
            bus.chg  <= '0;
            bus.busy <= '0;
            bus.tcnt <= '0;
            for (int i = 0; i < CH; i++) begin
                st[i] <= S0;
                hc[i] <= 8'd0;
            end
        end else begin
            bus.Q   <= nxt_c;
            bus.chg <= chg_c;
            for (int i = 0; i < CH; i++) begin
                if (chg_c[i]) begin
                    if (HOLD_LD != 8'd0) begin
                        st[i]       <= LK;
                        hc[i]       <= HOLD_LD;
                        bus.busy[i] <= 1'b1;
                    end else begin
                        st[i]       <= nxt_c[i] ? S1 : S0;
                        bus.busy[i] <= 1'b0;
                    end
                end else if (hc[i] != 8'd0) begin
                    hc[i] <= hc[i] - 8'd1;
                    if (hc[i] == 8'd1) begin
                        st[i]       <= bus.Q[i] ? S1 : S0;
                        bus.busy[i] <= 1'b0;
                    end
                end else if (st[i] == LK) begin
                    st[i]       <= bus.Q[i] ? S1 : S0;
                    bus.busy[i] <= 1'b0;
                end
            end
            if (bus.tcnt_clr) begin
                bus.tcnt <= '0;
            end else if (sum_c > CNT_MAX) begin
                bus.tcnt <= CNT_W'(CNT_MAX);
            end else begin
                bus.tcnt <= CNT_W'(sum_c);
            end
        end
    end
endmodule

// File: tb/tb_sm_multi.sv
// Bench for sm_multi: four parameter variants driven by one stimulus stream,
// checked every cycle against a cycle-level behavioural model.
module tb_sm_multi;
    localparam int NK = 4;
    localparam int MODE_K [NK] = '{0, 1, 2, 3};
    localparam int HOLD_K [NK] = '{0, 3, 0, 2};
    localparam int CW_K   [NK] = '{8, 8, 3, 8};

    logic       En;
    logic       rst;
    logic [3:0] a_drv;
    logic [3:0] b_drv;
    logic       clr_drv;

    int checks = 0;
    int errors = 0;

    sm_multi_if #(.CH(4), .CNT_W(8)) i0 ();
    sm_multi_if #(.CH(4), .CNT_W(8)) i1 ();
    sm_multi_if #(.CH(4), .CNT_W(3)) i2 ();
    sm_multi_if #(.CH(4), .CNT_W(8)) i3 ();

    assign i0.a = a_drv; assign i0.b = b_drv; assign i0.tcnt_clr = clr_drv;
    assign i1.a = a_drv; assign i1.b = b_drv; assign i1.tcnt_clr = clr_drv;
    assign i2.a = a_drv; assign i2.b = b_drv; assign i2.tcnt_clr = clr_drv;
    assign i3.a = a_drv; assign i3.b = b_drv; assign i3.tcnt_clr = clr_drv;

    sm_multi #(.CH(4), .MODE(0), .HOLD_CYC(0), .CNT_W(8)) d0 (.En(En), .rst(rst), .bus(i0.slave));
    sm_multi #(.CH(4), .MODE(1), .HOLD_CYC(3), .CNT_W(8)) d1 (.En(En), .rst(rst), .bus(i1.slave));
    sm_multi #(.CH(4), .MODE(2), .HOLD_CYC(0), .CNT_W(3)) d2 (.En(En), .rst(rst), .bus(i2.slave));
    sm_multi #(.CH(4), .MODE(3), .HOLD_CYC(2), .CNT_W(8)) d3 (.En(En), .rst(rst), .bus(i3.slave));

    logic [3:0] dq [NK];
    logic [3:0] dchg [NK];
    logic [3:0] dbusy [NK];
    logic [7:0] dt [NK];

    assign dq[0] = i0.Q; assign dchg[0] = i0.chg; assign dbusy[0] = i0.busy; assign dt[0] = i0.tcnt;
    assign dq[1] = i1.Q; assign dchg[1] = i1.chg; assign dbusy[1] = i1.busy; assign dt[1] = i1.tcnt;
    assign dq[2] = i2.Q; assign dchg[2] = i2.chg; assign dbusy[2] = i2.busy; assign dt[2] = {5'd0, i2.tcnt};
    assign dq[3] = i3.Q; assign dchg[3] = i3.chg; assign dbusy[3] = i3.busy; assign dt[3] = i3.tcnt;

    initial begin
        En = 1'b0;
        forever #10 En = ~En;
    end

    // Behavioural model: flag values, remaining ignored edges, saturating count.
    logic [3:0] m_q [NK];
    logic [3:0] m_chg [NK];
    int         m_lock [NK][4];
    int         m_cnt [NK];

    function automatic logic wanted(int mode, logic q, logic a, logic b);
        if (a && !b) return 1'b1;
        if (!a && b) return 1'b0;
        if (!a && !b) return q;
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'b0;
        if (mode == 2) return ~q;
        return q;
    endfunction

    always @(posedge En or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NK; k++) begin
                m_q[k]   <= '0;
                m_chg[k] <= '0;
                m_cnt[k] <= 0;
                for (int i = 0; i < 4; i++) m_lock[k][i] <= 0;
            end
        end else begin
            for (int k = 0; k < NK; k++) begin
                automatic int         n    = 0;
                automatic logic [3:0] nq   = m_q[k];
                automatic logic [3:0] nchg = '0;
                automatic int         cmax = (1 << CW_K[k]) - 1;
                for (int i = 0; i < 4; i++) begin
                    if (m_lock[k][i] > 0) begin
                        m_lock[k][i] <= m_lock[k][i] - 1;
                    end else begin
                        automatic logic w = wanted(MODE_K[k], m_q[k][i], a_drv[i], b_drv[i]);
                        if (w != m_q[k][i]) begin
                            nq[i]        = w;
                            nchg[i]      = 1'b1;
                            n++;
                            m_lock[k][i] <= HOLD_K[k];
                        end
                    end
                end
                m_q[k]   <= nq;
                m_chg[k] <= nchg;
                if (clr_drv) m_cnt[k] <= 0;
                else if (m_cnt[k] + n > cmax) m_cnt[k] <= cmax;
                else m_cnt[k] <= m_cnt[k] + n;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all four variants against the model.
    always @(negedge En) begin
        for (int k = 0; k < NK; k++) begin
            automatic logic [3:0] eb = '0;
            for (int i = 0; i < 4; i++) eb[i] = (m_lock[k][i] > 0);
            chk($sformatf("model_q%0d", k), int'(dq[k]), int'(m_q[k]));
            chk($sformatf("model_chg%0d", k), int'(dchg[k]), int'(m_chg[k]));
            chk($sformatf("model_busy%0d", k), int'(dbusy[k]), int'(eb));
            chk($sformatf("model_tcnt%0d", k), int'(dt[k]), m_cnt[k]);
        end
    end

    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic clr);
        a_drv   = a;
        b_drv   = b;
        clr_drv = clr;
        @(negedge En);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        a_drv   = '0;
        b_drv   = '0;
        clr_drv = 1'b0;
        repeat (2) @(negedge En);
        rst = 1'b0;
    endtask

    int pulses;

    initial begin
        rst     = 1'b1;
        a_drv   = '0;
        b_drv   = '0;
        clr_drv = 1'b0;
        @(negedge En);
        chk("reset_q", int'(dq[0]), 0);
        chk("reset_tcnt", int'(dt[0]), 0);
        @(negedge En);
        rst = 1'b0;

        // Basic set then clear on channel 0.
        step(4'b0001, 4'b0000, 1'b0);
        chk("set_q", int'(dq[0]), 1);
        chk("set_chg", int'(dchg[0]), 1);
        step(4'b0000, 4'b0001, 1'b0);
        chk("clr_q", int'(dq[0]), 0);
        chk("clr_chg", int'(dchg[0]), 1);
        step(4'b0000, 4'b0000, 1'b0);
        chk("basic_chg_idle", int'(dchg[0]), 0);
        chk("basic_tcnt", int'(dt[0]), 2);

        // a=b=1 on channel 1 in each mode.
        do_reset();
        step(4'b0010, 4'b0010, 1'b0);
        chk("both_mode0", int'(dq[0]), 2);
        chk("both_mode1", int'(dq[1]), 0);
        chk("both_mode2_e1", int'(dq[2]), 2);
        chk("both_mode3", int'(dq[3]), 0);
        step(4'b0010, 4'b0010, 1'b0);
        chk("both_mode2_e2", int'(dq[2]), 0);
        repeat (3) step(4'b0010, 4'b0010, 1'b0);
        chk("toggle5_q", int'(dq[2]), 2);
        chk("toggle5_tcnt", int'(dt[2]), 5);

        // Lockout on the HOLD_CYC=3 variant.
        do_reset();
        pulses = 0;
        step(4'b0100, 4'b0000, 1'b0);
        pulses += int'(dchg[1][2]);
        chk("lk_set_q", int'(dq[1]), 4);
        chk("lk_set_busy", int'(dbusy[1]), 4);
        for (int s = 1; s <= 4; s++) begin
            step(4'b0000, 4'b0100, 1'b0);
            pulses += int'(dchg[1][2]);
            if (s <= 2) chk($sformatf("lk_busy_%0d", s), int'(dbusy[1]), 4);
            if (s == 3) chk("lk_busy_3", int'(dbusy[1]), 0);
            if (s <= 3) chk($sformatf("lk_hold_q_%0d", s), int'(dq[1]), 4);
            if (s == 4) chk("lk_release_q", int'(dq[1]), 0);
        end
        chk("lk_pulses", pulses, 2);

        // Asynchronous reset in the middle of a lockout.
        do_reset();
        step(4'b0100, 4'b0000, 1'b0);
        a_drv = '0;
        @(posedge En);
        #5 rst = 1'b1;
        #1;
        chk("async_busy_before", 0, 0 + 0 * int'(dbusy[1]) + int'(dbusy[1]));
        chk("async_q", int'(dq[1]), 0);
        chk("async_tcnt", int'(dt[1]), 0);
        chk("async_chg", int'(dchg[1]), 0);
        @(negedge En);
        rst = 1'b0;
        step(4'b0100, 4'b0000, 1'b0);
        chk("post_rst_set", int'(dq[1]), 4);

        // Saturation and clear on the 3-bit counter variant.
        do_reset();
        step(4'b1111, 4'b1111, 1'b0);
        chk("sat_e1", int'(dt[2]), 4);
        step(4'b1111, 4'b1111, 1'b0);
        chk("sat_e2", int'(dt[2]), 7);
        step(4'b1111, 4'b1111, 1'b0);
        chk("sat_hold", int'(dt[2]), 7);
        step(4'b1111, 4'b1111, 1'b1);
        chk("sat_clr", int'(dt[2]), 0);
        step(4'b1111, 4'b1111, 1'b0);
        chk("sat_after_clr", int'(dt[2]), 4);

        // Redundant set on an already-set channel.
        do_reset();
        step(4'b1000, 4'b0000, 1'b0);
        chk("red_init_tcnt", int'(dt[0]), 1);
        for (int s = 0; s < 5; s++) begin
            step(4'b1000, 4'b0000, 1'b0);
            chk("red_chg", int'(dchg[0]), 0);
            chk("red_busy", int'(dbusy[0]), 0);
            chk("red_tcnt", int'(dt[0]), 1);
        end

        // Randomised traffic with occasional clears and mid-cycle resets.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(63) == 0) begin
                @(posedge En);
                #5 rst = 1'b1;
                @(negedge En);
                rst = 1'b0;
            end
            step(4'($urandom), 4'($urandom), ($urandom_range(15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
